// File: rtl/data_cache_ctrl_pkg.sv
// Shared constants, FSM encoding and address-field helpers for the L1 data cache.
package data_cache_ctrl_pkg;

    localparam int LINES  = 16;
    localparam int ADDR_W = 32;
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - 2 - IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return addr[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:IDX_W+2];
    endfunction

endpackage

// File: rtl/data_cache_ctrl_if.sv
// CPU-side and DataMemory-side bus of the data cache; slave is the cache, master is its environment.
interface data_cache_ctrl_if;

    logic                                   cpu_MemRead;
    logic                                   cpu_MemWrite;
    logic [data_cache_ctrl_pkg::ADDR_W-1:0] cpu_Address;
    logic [31:0]                            cpu_WriteData;
    logic [31:0]                            cpu_ReadData;
    logic                                   Stall;
    logic                                   mem_MemWrite;
    logic [data_cache_ctrl_pkg::ADDR_W-1:0] mem_Address;
    logic [31:0]                            mem_WriteData;
    logic [31:0]                            mem_ReadData;
    logic                                   mem_MemReady;

    modport slave (
        input  cpu_MemRead, cpu_MemWrite, cpu_Address, cpu_WriteData,
        output cpu_ReadData, Stall,
        output mem_MemWrite, mem_Address, mem_WriteData,
        input  mem_ReadData, mem_MemReady
    );

    modport master (
        output cpu_MemRead, cpu_MemWrite, cpu_Address, cpu_WriteData,
        input  cpu_ReadData, Stall,
        input  mem_MemWrite, mem_Address, mem_WriteData,
        output mem_ReadData, mem_MemReady
    );

endinterface

// File: rtl/data_cache_ctrl_array.sv
// Valid/tag/data storage: asynchronous read port, one write port, valid bits cleared by reset.
module data_cache_ctrl_array
    import data_cache_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    // Any write (fill or write-hit refresh) leaves the line valid.
    always_comb begin
        valid_d = valid_q;
        if (we_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits: only these need reset, tag/data are qualified by them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= {LINES{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Read hits answer combinationally; misses and writes stall the pipeline until DataMemory is ready.
module data_cache_ctrl
    import data_cache_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    data_cache_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_write_q, mem_write_d;
    logic              op_write_q, op_write_d;
    logic [31:0]       fill_q, fill_d;

    logic [ADDR_W-1:0] look_addr_s;
    logic              rd_valid_s;
    logic [TAG_W-1:0]  rd_tag_s;
    logic [31:0]       rd_data_s;
    logic              hit_s;
    logic              cpu_rd_s;
    logic              need_mem_s;
    logic              arr_we_s;
    logic [31:0]       arr_wdata_s;

    // While idle, look up the live CPU address; once in flight, the latched copy.
    assign look_addr_s = (state_q == ST_IDLE) ? bus.cpu_Address : mem_addr_q;
    assign hit_s       = rd_valid_s && (rd_tag_s == addr_tag(look_addr_s));
    assign cpu_rd_s    = bus.cpu_MemRead && !bus.cpu_MemWrite;
    assign need_mem_s  = bus.cpu_MemWrite || (bus.cpu_MemRead && !hit_s);

    data_cache_ctrl_array u_array (
        .clk        (clk),
        .rst_n      (reset),
        .rd_idx_i   (addr_idx(look_addr_s)),
        .rd_valid_o (rd_valid_s),
        .rd_tag_o   (rd_tag_s),
        .rd_data_o  (rd_data_s),
        .we_i       (arr_we_s),
        .wr_idx_i   (addr_idx(mem_addr_q)),
        .wr_tag_i   (addr_tag(mem_addr_q)),
        .wr_data_i  (arr_wdata_s)
    );

    // Next-state logic; the line is only touched in the cycle MemReady completes the access.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = mem_write_q;
        op_write_d  = op_write_q;
        fill_d      = fill_q;
        arr_we_s    = 1'b0;
        arr_wdata_s = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (need_mem_s) begin
                    state_d     = ST_ISSUE;
                    mem_addr_d  = bus.cpu_Address;
                    mem_wdata_d = bus.cpu_WriteData;
                    mem_write_d = bus.cpu_MemWrite;
                    op_write_d  = bus.cpu_MemWrite;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mem_MemReady) begin
                    state_d     = ST_DONE;
                    mem_write_d = 1'b0;
                    if (!op_write_q) begin
                        arr_we_s    = 1'b1;
                        arr_wdata_s = bus.mem_ReadData;
                        fill_d      = bus.mem_ReadData;
                    end else begin
                        arr_we_s    = hit_s;
                        arr_wdata_s = mem_wdata_q;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // State and request latches; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= 32'd0;
            mem_write_q <= 1'b0;
            op_write_q  <= 1'b0;
            fill_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            op_write_q  <= op_write_d;
            fill_q      <= fill_d;
        end
    end

    assign bus.mem_MemWrite  = mem_write_q;
    assign bus.mem_Address   = mem_addr_q;
    assign bus.mem_WriteData = mem_wdata_q;

    // Stall must rise in the request cycle itself, so it and hit data stay combinational.
    always_comb begin
        bus.Stall        = 1'b0;
        bus.cpu_ReadData = 32'd0;
        if (!reset) begin
            bus.Stall        = 1'b0;
            bus.cpu_ReadData = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bus.Stall = need_mem_s;
                    if (cpu_rd_s && hit_s) begin
                        bus.cpu_ReadData = rd_data_s;
                    end else begin
                        bus.cpu_ReadData = 32'd0;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    bus.Stall = 1'b1;
                end
                ST_DONE: begin
                    if (!op_write_q) begin
                        bus.cpu_ReadData = fill_q;
                    end else begin
                        bus.cpu_ReadData = 32'd0;
                    end
                end
                default: begin
                    bus.Stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl with a DataMemory model of fixed delay ND=3.
module tb_data_cache_ctrl;

    localparam int ND = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    data_cache_ctrl_if bus ();

    data_cache_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // DataMemory model: ready in the ND-th cycle after ISSUE, counted from the stall's first edge.
    logic [31:0] dmem [0:255];
    int          mem_cnt      = 0;
    int          mem_accesses = 0;

    assign bus.mem_MemReady = (mem_cnt == ND + 1);
    assign bus.mem_ReadData = dmem[bus.mem_Address[9:2]];

    always @(posedge clk) begin
        if (bus.Stall === 1'b1) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
        if (bus.mem_MemReady) begin
            mem_accesses <= mem_accesses + 1;
            if (bus.mem_MemWrite) begin
                dmem[bus.mem_Address[9:2]] <= bus.mem_WriteData;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        bus.cpu_MemRead   = 1'b0;
        bus.cpu_MemWrite  = 1'b0;
        bus.cpu_Address   = 32'd0;
        bus.cpu_WriteData = 32'd0;
    endtask

    // Start a request at a falling edge, count stalled cycles, check the completion cycle.
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_stall, input int exp_mw,
                          input logic [31:0] exp_rdata, input string tag);
        int n;
        int mw;
        int acc0;
        bus.cpu_MemWrite  = wr;
        bus.cpu_MemRead   = rd;
        bus.cpu_Address   = addr;
        bus.cpu_WriteData = wdata;
        acc0 = mem_accesses;
        n    = 0;
        mw   = 0;
        #1;
        while (bus.Stall === 1'b1 && n < 30) begin
            if (bus.mem_MemWrite === 1'b1) mw++;
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, " stall_cycles"}, n, exp_stall);
        check({tag, " memwrite_cycles"}, mw, exp_mw);
        check({tag, " mem_accesses"}, mem_accesses - acc0, (exp_stall > 0) ? 32'd1 : 32'd0);
        if (exp_stall > 0) begin
            check({tag, " done_memwrite"}, {31'd0, bus.mem_MemWrite}, 32'd0);
            check({tag, " mem_address"}, bus.mem_Address, addr);
        end
        if (wr) begin
            check({tag, " mem_wdata"}, bus.mem_WriteData, wdata);
        end
        if (rd && !wr) begin
            check({tag, " read_data"}, bus.cpu_ReadData, exp_rdata);
        end
        @(negedge clk);
        set_idle();
    endtask

    initial begin
        set_idle();
        #2;
        check("rst stall", {31'd0, bus.Stall}, 32'd0);
        check("rst memwrite", {31'd0, bus.mem_MemWrite}, 32'd0);
        check("rst mem_address", bus.mem_Address, 32'd0);
        check("rst mem_wdata", bus.mem_WriteData, 32'd0);
        check("rst read_data", bus.cpu_ReadData, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        access(1'b1, 1'b0, 32'd64,  32'd45,  5, 4, 32'd0,   "wr45@64");
        access(1'b0, 1'b1, 32'd64,  32'd0,   5, 0, 32'd45,  "rd@64 miss");
        access(1'b0, 1'b1, 32'd64,  32'd0,   0, 0, 32'd45,  "rd@64 hit");
        #1;
        check("idle read_data", bus.cpu_ReadData, 32'd0);
        check("idle stall", {31'd0, bus.Stall}, 32'd0);

        access(1'b1, 1'b0, 32'd128, 32'd100, 5, 4, 32'd0,   "wr100@128");
        access(1'b0, 1'b1, 32'd128, 32'd0,   5, 0, 32'd100, "rd@128 miss");
        access(1'b0, 1'b1, 32'd128, 32'd0,   0, 0, 32'd100, "rd@128 hit");

        // 128 evicted line 0; bring 64 back, then write through it.
        access(1'b0, 1'b1, 32'd64,  32'd0,   5, 0, 32'd45,  "rd@64 refill");
        access(1'b1, 1'b0, 32'd64,  32'd77,  5, 4, 32'd0,   "wr77@64 hit");
        access(1'b0, 1'b1, 32'd64,  32'd0,   0, 0, 32'd77,  "rd@64 hit77");
        check("dmem@64", dmem[16], 32'd77);

        access(1'b0, 1'b1, 32'd128, 32'd0,   5, 0, 32'd100, "rd@128 evict");
        access(1'b0, 1'b1, 32'd64,  32'd0,   5, 0, 32'd77,  "rd@64 after evict");

        // Both strobes high: the write wins.
        access(1'b1, 1'b1, 32'd192, 32'd55,  5, 4, 32'd0,   "rdwr@192");
        access(1'b0, 1'b1, 32'd192, 32'd0,   5, 0, 32'd55,  "rd@192 miss");

        // Reset in WAIT of a read miss.
        access(1'b0, 1'b1, 32'd64,  32'd0,   5, 0, 32'd77,  "rd@64 pre-reset");
        bus.cpu_MemRead = 1'b1;
        bus.cpu_Address = 32'd128;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("wait stall", {31'd0, bus.Stall}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort stall", {31'd0, bus.Stall}, 32'd0);
        check("abort memwrite", {31'd0, bus.mem_MemWrite}, 32'd0);
        set_idle();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        access(1'b0, 1'b1, 32'd128, 32'd0,   5, 0, 32'd100, "rd@128 post-reset");
        access(1'b0, 1'b1, 32'd64,  32'd0,   5, 0, 32'd77,  "rd@64 post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
